// File: rtl/debounce_pkg.sv
// Shared types and counter widths for the multi-channel button debouncer.
// Auto-repeat (enabled by defining DEBOUNCE_REPEAT_EN) uses HOLD_W.
package debounce_pkg;

    typedef enum logic [1:0] {
        IDLE_LOW    = 2'd0,
        LOW_TO_HIGH = 2'd1,
        HIGH        = 2'd2,
        HIGH_TO_LOW = 2'd3
    } chan_state_e;

    localparam int CNT_W  = 16;
    localparam int HOLD_W = 20;

endpackage

// File: rtl/debounce_channel.sv
// One debounce channel: 2-flop synchroniser, 4-state debounce FSM, registered outputs.
// Optional auto-repeat of press pulses while held, enabled by defining DEBOUNCE_REPEAT_EN.
module debounce_channel #(
    parameter int RISE_CLKS        = 25,
    parameter int FALL_CLKS        = 50,
    parameter int REPEAT_DLY_CLKS  = 500000,
    parameter int REPEAT_RATE_CLKS = 100000
) (
    input  logic CLK,
    input  logic RST,
    input  logic btn,
    output logic db_level,
    output logic press_pulse,
    output logic release_pulse
);
    import debounce_pkg::*;

    localparam logic [CNT_W-1:0] RISE_CNT = CNT_W'(RISE_CLKS);
    localparam logic [CNT_W-1:0] FALL_CNT = CNT_W'(FALL_CLKS);

    logic             sync_1;
    logic             sync_s;
    chan_state_e      state;
    chan_state_e      state_nxt;
    chan_state_e      prev_state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             rep_hit;
    logic             db_nxt;
    logic             press_nxt;
    logic             release_nxt;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync_1 <= 1'b0;
            sync_s <= 1'b0;
        end else begin
            sync_1 <= btn;
            sync_s <= sync_1;
        end
    end

    // prev_state lets the output stage detect the first cycle of a new state.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= IDLE_LOW;
            prev_state <= IDLE_LOW;
            cnt        <= '0;
        end else begin
            state      <= state_nxt;
            prev_state <= state;
            cnt        <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE_LOW: begin
                if (sync_s) begin
                    state_nxt = LOW_TO_HIGH;
                    cnt_nxt   = CNT_W'(1);
                end else begin
                    cnt_nxt   = '0;
                end
            end
            LOW_TO_HIGH: begin
                if (!sync_s) begin
                    state_nxt = IDLE_LOW;
                    cnt_nxt   = '0;
                end else if (cnt == RISE_CNT) begin
                    state_nxt = HIGH;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt   = cnt + CNT_W'(1);
                end
            end
            HIGH: begin
                if (!sync_s) begin
                    state_nxt = HIGH_TO_LOW;
                    cnt_nxt   = CNT_W'(1);
                end
            end
            HIGH_TO_LOW: begin
                if (sync_s) begin
                    state_nxt = HIGH;
                    cnt_nxt   = '0;
                end else if (cnt == FALL_CNT) begin
                    state_nxt = IDLE_LOW;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt   = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE_LOW;
                cnt_nxt   = '0;
            end
        endcase
    end

`ifdef DEBOUNCE_REPEAT_EN
    localparam logic [HOLD_W-1:0] DLY_CNT  = HOLD_W'(REPEAT_DLY_CLKS);
    localparam logic [HOLD_W-1:0] RATE_CNT = HOLD_W'(REPEAT_RATE_CLKS);

    logic [HOLD_W-1:0] hold;
    logic              rep_phase;

    // After the first repeat the counter restarts and the target switches to the rate.
    assign rep_hit = (state == HIGH) && (hold == (rep_phase ? RATE_CNT : DLY_CNT));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            hold      <= '0;
            rep_phase <= 1'b0;
        end else begin
            case (state)
                IDLE_LOW: begin
                    hold      <= '0;
                    rep_phase <= 1'b0;
                end
                HIGH: begin
                    if (rep_hit) begin
                        hold      <= HOLD_W'(1);
                        rep_phase <= 1'b1;
                    end else begin
                        hold      <= hold + HOLD_W'(1);
                    end
                end
                default: begin
                    hold      <= hold;
                    rep_phase <= rep_phase;
                end
            endcase
        end
    end
`else
    localparam int repeat_cfg_unused = REPEAT_DLY_CLKS + REPEAT_RATE_CLKS;

    assign rep_hit = 1'b0;
`endif

    always_comb begin
        db_nxt      = (state == HIGH) || (state == HIGH_TO_LOW);
        press_nxt   = ((state == HIGH) && (prev_state == LOW_TO_HIGH)) || rep_hit;
        release_nxt = (state == IDLE_LOW) && (prev_state == HIGH_TO_LOW);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            db_level      <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            db_level      <= db_nxt;
            press_pulse   <= press_nxt;
            release_pulse <= release_nxt;
        end
    end

endmodule

// File: rtl/multi_debouncer.sv
// N_CH independent button debouncers sharing one clock; ANY_PRESS ORs the press pulses.
// Define DEBOUNCE_REPEAT_EN to enable auto-repeat press pulses while a button is held.
module multi_debouncer #(
    parameter int N_CH             = 5,
    parameter int RISE_CLKS        = 25,
    parameter int FALL_CLKS        = 50,
    parameter int REPEAT_DLY_CLKS  = 500000,
    parameter int REPEAT_RATE_CLKS = 100000
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [N_CH-1:0] BTN,
    output logic [N_CH-1:0] DB_LEVEL,
    output logic [N_CH-1:0] PRESS,
    output logic [N_CH-1:0] RELEASE,
    output logic            ANY_PRESS
);

    for (genvar g = 0; g < N_CH; g++) begin : g_chan
        debounce_channel #(
            .RISE_CLKS       (RISE_CLKS),
            .FALL_CLKS       (FALL_CLKS),
            .REPEAT_DLY_CLKS (REPEAT_DLY_CLKS),
            .REPEAT_RATE_CLKS(REPEAT_RATE_CLKS)
        ) u_chan (
            .CLK          (CLK),
            .RST          (RST),
            .btn          (BTN[g]),
            .db_level     (DB_LEVEL[g]),
            .press_pulse  (PRESS[g]),
            .release_pulse(RELEASE[g])
        );
    end

    // Combinational from the registered pulses so it adds no latency.
    assign ANY_PRESS = |PRESS;

endmodule

// File: tb/tb_multi_debouncer.sv
// Directed, table-driven bench for multi_debouncer (4 channels, short debounce windows).
module tb_multi_debouncer;

    localparam int N_CH  = 4;
    localparam int RISE  = 4;
    localparam int FALL  = 8;
    localparam int DLY   = 20;
    localparam int RATE  = 10;
    localparam int N_VEC = 67;
`ifdef DEBOUNCE_REPEAT_EN
    localparam bit REPEAT_ON = 1'b1;
`else
    localparam bit REPEAT_ON = 1'b0;
`endif

    logic            clk;
    logic            rst;
    logic [N_CH-1:0] btn;
    logic [N_CH-1:0] db_level;
    logic [N_CH-1:0] press;
    logic [N_CH-1:0] release_v;
    logic            any_press;

    int checks;
    int errors;

    typedef struct {
        logic [N_CH-1:0] btn;
        logic [N_CH-1:0] db;
        logic [N_CH-1:0] press;
        logic [N_CH-1:0] rel;
        logic            any;
    } vec_t;

    vec_t            tbl [N_VEC];
    logic [N_CH-1:0] exp_q [$];

    multi_debouncer #(
        .N_CH            (N_CH),
        .RISE_CLKS       (RISE),
        .FALL_CLKS       (FALL),
        .REPEAT_DLY_CLKS (DLY),
        .REPEAT_RATE_CLKS(RATE)
    ) dut (
        .CLK      (clk),
        .RST      (rst),
        .BTN      (btn),
        .DB_LEVEL (db_level),
        .PRESS    (press),
        .RELEASE  (release_v),
        .ANY_PRESS(any_press)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    // press pulse expected from a press accepted at cycle p, including auto-repeats
    function automatic bit press_at(int i, int p);
        if (i == p) return 1'b1;
        if (REPEAT_ON && i >= p + DLY && ((i - p - DLY) % RATE) == 0) return 1'b1;
        return 1'b0;
    endfunction

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        btn    = N_CH'($urandom_range(0, 15));

        // Channel 0 pressed at 0, channel 1 bounces (3 high / 1 low x5), channels 2,3 at 12.
        for (int i = 0; i < N_VEC; i++) begin
            tbl[i].btn[0]   = 1'b1;
            tbl[i].btn[1]   = (i < 20) && ((i % 4) < 3);
            tbl[i].btn[2]   = (i >= 12);
            tbl[i].btn[3]   = (i >= 12);
            tbl[i].db       = {(i >= 19), (i >= 19), 1'b0, (i >= 7)};
            tbl[i].press    = {press_at(i, 19), press_at(i, 19), 1'b0, press_at(i, 7)};
            tbl[i].rel      = '0;
            tbl[i].any      = press_at(i, 7) || press_at(i, 19);
        end

        // reset state
        tick();
        tick();
        check("reset db_level", 32'(db_level), 32'h0);
        check("reset press", 32'(press), 32'h0);
        check("reset release", 32'(release_v), 32'h0);
        check("reset any_press", 32'(any_press), 32'h0);
        btn = '0;
        #3 rst = 1'b0;

        // table-driven main sequence
        for (int i = 0; i < N_VEC; i++) begin
            btn = tbl[i].btn;
            tick();
            check($sformatf("vec%0d db_level", i), 32'(db_level), 32'(tbl[i].db));
            check($sformatf("vec%0d press", i), 32'(press), 32'(tbl[i].press));
            check($sformatf("vec%0d release", i), 32'(release_v), 32'(tbl[i].rel));
            check($sformatf("vec%0d any_press", i), 32'(any_press), 32'(tbl[i].any));
        end

        // channel 0 release with a 2-cycle high glitch; final fall at j=5
        for (int j = 0; j < 20; j++) begin
            btn[0] = (j == 3 || j == 4);
            tick();
            check($sformatf("glitch%0d release0", j), 32'(release_v[0]), 32'(j == 5 + FALL + 3));
            check($sformatf("glitch%0d db0", j), 32'(db_level[0]), 32'(j < 5 + FALL + 3));
        end

        // reset in the middle of channel 1 LOW_TO_HIGH, buttons 1..3 held through it
        btn = 4'b1110;
        for (int j = 0; j < 4; j++) tick();
        #2 rst = 1'b1;
        #1;
        check("midrst db_level", 32'(db_level), 32'h0);
        check("midrst press", 32'(press), 32'h0);
        check("midrst release", 32'(release_v), 32'h0);
        check("midrst any_press", 32'(any_press), 32'h0);
        tick();
        tick();
        #3 rst = 1'b0;
        for (int i = 0; i < 13; i++) exp_q.push_back((i == RISE + 3) ? 4'b1110 : 4'b0000);
        for (int i = 0; i < 13; i++) begin
            logic [N_CH-1:0] exp_p;
            tick();
            exp_p = exp_q.pop_front();
            check($sformatf("postrst%0d press", i), 32'(press), 32'(exp_p));
            check($sformatf("postrst%0d any_press", i), 32'(any_press), 32'(|exp_p));
            check($sformatf("postrst%0d db_level", i), 32'(db_level),
                  32'((i >= RISE + 3) ? 4'b1110 : 4'b0000));
            check($sformatf("postrst%0d release", i), 32'(release_v), 32'h0);
        end

        // final report
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
